// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered display word,
// one-hot digit stepping with per-slot blanking, and a shared external decoder.
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  load_i,
    input  logic                  lz_en_i,
    input  logic [DIGITS-1:0]     dp_mask_i,
    output logic [3:0]            nibble_o,
    input  logic [6:0]            d7seg_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     digit_en_o,
    output logic                  frame_done_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   act_q, act_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pend_v_q, pend_v_d;

    logic                  slot_end;
    logic                  wrap;
    logic                  all_zero;
    logic [DIGITS-1:0]     supp;
    logic                  cur_supp;
    logic                  cur_dp;
    logic                  lit;

    assign slot_end = (cnt_q == CNT_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);

    // A load on the commit edge bypasses the pending buffer so it is never lost.
    always_comb begin
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        act_d    = act_q;
        if (load_i) begin
            pend_d   = value_i;
            pend_v_d = 1'b1;
        end
        if (wrap) begin
            if (load_i) begin
                act_d = value_i;
            end else if (pend_v_q) begin
                act_d = pend_q;
            end
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            act_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    // A digit is blanked as a leading zero when it and every higher nibble are zero.
    always_comb begin
        all_zero = 1'b1;
        supp     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (act_q[4*i +: 4] == 4'h0);
            if (i > 0) begin
                supp[i] = lz_en_i && all_zero;
            end
        end
    end

    always_comb begin
        nibble_o = '0;
        cur_supp = 1'b0;
        cur_dp   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nibble_o = act_q[4*i +: 4];
                cur_supp = supp[i];
                cur_dp   = dp_mask_i[i];
            end
        end
    end

    assign lit          = (cnt_q >= CNT_BLANK) && !cur_supp;
    assign digit_en_o   = lit ? (DIGITS'(1) << idx_q) : '0;
    assign seg_o        = lit ? d7seg_i : 7'h00;
    assign dp_o         = lit && cur_dp;
    assign frame_done_o = wrap;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller that shares one combinational hex-to-7-segment decoder across a bank of common-enable digits. It holds a double-buffered display word and steps a one-hot digit enable through the digits at a programmable rate. For each slot it presents that digit's nibble to the shared decoder and gates the returned segment pattern. It sits between the user/datapath logic that produces the display value and the board's segment/digit pins.

## Interface
- DIGITS, 4: number of digits scanned; legal 1..8.
- DIV, 50000: clock cycles per digit slot; legal DIV ≥ BLANK+1.
- BLANK, 16: cycles at the start of each slot with all digits off (anti-ghosting); legal 0..DIV-1.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  display word; nibble i drives digit i (digit 0 = least significant, rightmost).
- load  in  1  one-cycle strobe: capture value into the pending buffer.
- lz_en  in  1  leading-zero suppression enable, sampled each cycle.
- dp_mask  in  DIGITS  decimal-point request per digit, sampled each cycle.
- nibble  out  4  nibble of the current digit, to the shared decoder's input.
- d7seg_in  in  7  segment pattern returned by the shared decoder (bit0 = a … bit6 = g, active-high).
- seg  out  7  gated segment drive, active-high.
- dp  out  1  gated decimal point, active-high.
- digit_en  out  DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  one-cycle pulse on the last cycle of each full scan.

## Operation
- State: slot counter cnt (0..DIV-1), digit index idx (0..DIGITS-1), pending register pend plus pend_v flag, active register act.
- cnt increments every cycle. At DIV-1 it wraps to 0 and idx advances. idx wraps DIGITS-1 → 0.
- load=1: pend ← value, pend_v ← 1. Back-to-back loads: the last one wins.
- Commit happens on the edge where idx wraps DIGITS-1 → 0: if pend_v then act ← pend, pend_v ← 0.
- Load coinciding with the commit edge: act ← value (the new word), pend_v ← 0. No load is ever lost.
- nibble = act[4*idx +: 4] at all times, including during blanking.
- Suppression: with lz_en=1, digit i (i>0) is suppressed when nibbles i..DIGITS-1 of act are all zero. Digit 0 is never suppressed.
- Lit condition: cnt ≥ BLANK and the current digit is not suppressed.
- When lit: digit_en = 1<<idx, seg = d7seg_in, dp = dp_mask[idx].
- When not lit: digit_en = 0, seg = 0, dp = 0.
- frame_done = 1 exactly when cnt = DIV-1 and idx = DIGITS-1.
- Reset (asynchronous): cnt=0, idx=0, act=0, pend=0, pend_v=0. Outputs then read digit_en=0, seg=0, dp=0, frame_done=0, nibble=0.
- Reset mid-scan aborts the scan immediately and discards any pending word. Scanning restarts from digit 0 slot 0 on the first edge after rst deasserts.

## Timing
- All state is registered. nibble, digit_en, dp and frame_done are combinational from registers and inputs only, with no registered output stage.
- seg is combinational from d7seg_in. With a combinational decoder, seg is valid in the same cycle as nibble.
- Load to pending: 1 cycle.
- Load to displayed: up to one full frame (DIGITS*DIV cycles). Applies from the next frame boundary.
- Frame period: DIGITS*DIV cycles. frame_done period is identical.
- Per slot: BLANK dark cycles, then DIV-BLANK lit cycles.
- BLANK=0: a digit is lit for all DIV cycles, and enables switch directly from one digit to the next.
- DIGITS=1: idx stays 0, and every slot end is also a commit edge and a frame_done cycle.
- lz_en and dp_mask changes take effect in the same cycle. No glitch protection is required; callers change them at frame_done.

## Test plan
- Reset/idle (DIGITS=4, DIV=8, BLANK=2): hold rst 3 cycles, then release → digit_en=0 for cycles 0–1. digit_en=0001, nibble=0, seg=d7seg_in in cycles 2–7. digit_en=0010 at cycle 10. frame_done pulses at cycle 31, then again every 32 cycles.
- Double buffer: load value=16'h1234 mid-frame → nibble stays 0 until the wrap. In the next frame, slots 0..3 present nibbles 4,3,2,1. frame_done precedes the change by exactly 1 cycle.
- Load on commit edge: pend holds 16'hAAAA, and load 16'h5678 lands on the wrap edge → new frame shows 8,7,6,5. 16'hAAAA never appears.
- Leading zeros: act=16'h0040, lz_en=1 → digits 3 and 2 stay dark, and digits 1 and 0 light with nibbles 4 and 0. act=16'h0000 → only digit 0 lights, showing 0. With lz_en=0, all four digits light.
- Decimal point and gating: dp_mask=4'b0100 → dp=1 only during digit 2's lit cycles. dp and seg are 0 during every blank cycle, even when d7seg_in=7'h7f.
- Async reset mid-scan: assert rst between clock edges while idx=2 with a pending load → outputs go dark immediately. After release, the scan restarts at digit 0 with act=0 and the pending word discarded.
